// File: rtl/rv_lsu_if.sv
// Core request/response and data-memory port bundle for rv_lsu.
// master is the LSU view; slave is the view of the core plus memory around it.
interface rv_lsu_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;

  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;

  logic              mem_req;
  logic              mem_gnt;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;
  logic              mem_rvalid;
  logic [31:0]       mem_rdata;

  modport master (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready,
    output resp_valid, resp_rdata, resp_err,
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready,
    input  resp_valid, resp_rdata, resp_err,
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/rv_lsu.sv
// RV32I load/store unit: one outstanding access, word-addressed memory port with byte enables.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of force-aligning them.
module rv_lsu #(
  parameter int ADDR_W     = 32,
  parameter int RESET_HOLD = 0
) (
  input  logic     clk,
  input  logic     rst,
  rv_lsu_if.master bus
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t            state;
  state_t            state_nxt;

  logic [3:0]        hold_cnt;
  logic              hold_done;
  logic              ready;
  logic              mem_req_c;
  logic              resp_valid_c;
  logic              accept;
  logic              req_bad;
  logic              funct3_ok;
  logic [1:0]        off_eff;
  logic [3:0]        be_dec;
  logic [31:0]       wdata_dec;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [31:0]       load_data;

  logic              we_q;
  logic [2:0]        funct3_q;
  logic [1:0]        off_q;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        be_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic              err_q;

  assign accept = bus.req_valid && ready;

  // Request decode: legality, effective lane offset, byte enables and lane-replicated store data.
  always_comb begin
    funct3_ok = 1'b0;
    off_eff   = 2'b00;
    be_dec    = 4'b0000;
    wdata_dec = 32'h0;
    if (bus.req_we) begin
      funct3_ok = !bus.req_funct3[2] && (bus.req_funct3[1:0] != 2'b11);
    end else begin
      funct3_ok = (bus.req_funct3[1:0] != 2'b11) && (bus.req_funct3 != 3'b110);
    end
    case (bus.req_funct3[1:0])
      2'b00: begin
        off_eff   = bus.req_addr[1:0];
        be_dec    = 4'b0001 << off_eff;
        wdata_dec = {4{bus.req_wdata[7:0]}};
      end
      2'b01: begin
        off_eff   = {bus.req_addr[1], 1'b0};
        be_dec    = 4'b0011 << off_eff;
        wdata_dec = {2{bus.req_wdata[15:0]}};
      end
      2'b10: begin
        off_eff   = 2'b00;
        be_dec    = 4'b1111;
        wdata_dec = bus.req_wdata;
      end
      default: begin
        off_eff   = 2'b00;
        be_dec    = 4'b0000;
      end
    endcase
    if (!bus.req_we) begin
      wdata_dec = 32'h0;
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic misalign;
  assign misalign = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                    ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
  assign req_bad  = !funct3_ok || misalign;
`else
  assign req_bad  = !funct3_ok;
`endif

  always_comb begin
    load_data = 32'h0;
    ld_byte   = bus.mem_rdata[{off_q, 3'b000} +: 8];
    ld_half   = bus.mem_rdata[{off_q[1], 4'b0000} +: 16];
    case (funct3_q)
      3'b000:  load_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  load_data = {{16{ld_half[15]}}, ld_half};
      3'b010:  load_data = bus.mem_rdata;
      3'b100:  load_data = {24'h0, ld_byte};
      3'b101:  load_data = {16'h0, ld_half};
      default: load_data = 32'h0;
    endcase
  end

  // Post-reset hold: ready stays low for RESET_HOLD cycles beyond the first clock after release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_cnt  <= 4'(RESET_HOLD);
      hold_done <= 1'b0;
    end else if (hold_cnt != 4'd0) begin
      hold_cnt  <= hold_cnt - 4'd1;
    end else begin
      hold_done <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    ready        = 1'b0;
    mem_req_c    = 1'b0;
    resp_valid_c = 1'b0;
    case (state)
      IDLE: begin
        ready = hold_done;
        if (bus.req_valid && hold_done) begin
          state_nxt = req_bad ? RESP : REQ;
        end
      end
      REQ: begin
        mem_req_c = 1'b1;
        if (bus.mem_gnt) begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (bus.mem_rvalid) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        resp_valid_c = 1'b1;
        state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Memory-side fields are captured only for legal requests; response fields change only when a response is formed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      off_q    <= 2'b00;
      addr_q   <= '0;
      be_q     <= 4'b0000;
      wdata_q  <= 32'h0;
      rdata_q  <= 32'h0;
      err_q    <= 1'b0;
    end else begin
      if (accept && !req_bad) begin
        we_q     <= bus.req_we;
        funct3_q <= bus.req_funct3;
        off_q    <= off_eff;
        addr_q   <= {bus.req_addr[ADDR_W-1:2], 2'b00};
        be_q     <= be_dec;
        wdata_q  <= wdata_dec;
      end
      if (accept && req_bad) begin
        rdata_q <= 32'h0;
        err_q   <= 1'b1;
      end else if ((state == WAIT) && bus.mem_rvalid) begin
        rdata_q <= we_q ? 32'h0 : load_data;
        err_q   <= 1'b0;
      end
    end
  end

  assign bus.req_ready  = ready;
  assign bus.mem_req    = mem_req_c;
  assign bus.resp_valid = resp_valid_c;
  assign bus.mem_we     = we_q;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_be     = be_q;
  assign bus.mem_wdata  = wdata_q;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;

endmodule

// File: tb/tb_rv_lsu.sv
// Directed bench for rv_lsu: drives core requests and a hand-timed memory, compares against fixed expectations.
module tb_rv_lsu;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  rv_lsu_if #(.ADDR_W(32)) bus ();

  rv_lsu #(.ADDR_W(32), .RESET_HOLD(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] obs_addr;
  logic [31:0] obs_wdata;
  logic [31:0] obs_rdata;
  logic [3:0]  obs_be;
  logic        obs_we;
  logic        obs_err;
  logic        obs_saw_req;
  logic        obs_req_ok;
  logic        obs_ready_early;
  logic        obs_pulse_ok;
  logic        obs_ready_after;
  logic        obs_hold;
  int          obs_lat;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic waitReady();
    int cyc;
    cyc = 0;
    while (!bus.req_ready && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    checkOutput("ready_before_req", 32'(bus.req_ready), 32'd1);
  endtask

  // One full access: latency counted in cycles after the accepting edge; mem_gnt after gnt_delay request cycles.
  task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [31:0] rdata, input int gnt_delay);
    int   cyc;
    int   req_cycles;
    logic granted;
    waitReady();
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    @(posedge clk); #1;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    obs_saw_req     = 1'b0;
    obs_req_ok      = 1'b1;
    obs_ready_early = 1'b0;
    obs_addr = 32'h0; obs_be = 4'h0; obs_wdata = 32'h0; obs_we = 1'b0;
    req_cycles = 0;
    granted    = 1'b0;
    cyc        = 1;
    while (!bus.resp_valid && cyc <= 40) begin
      if (bus.req_ready) obs_ready_early = 1'b1;
      bus.mem_rvalid = granted;
      bus.mem_rdata  = granted ? rdata : 32'h0;
      bus.mem_gnt    = 1'b0;
      if (bus.mem_req) begin
        if (granted) obs_req_ok = 1'b0;
        if (!obs_saw_req) begin
          obs_addr = bus.mem_addr; obs_be = bus.mem_be; obs_wdata = bus.mem_wdata; obs_we = bus.mem_we;
        end else if (bus.mem_addr != obs_addr || bus.mem_be != obs_be ||
                     bus.mem_wdata != obs_wdata || bus.mem_we != obs_we) begin
          obs_req_ok = 1'b0;
        end
        obs_saw_req = 1'b1;
        req_cycles++;
        if (req_cycles > gnt_delay) bus.mem_gnt = 1'b1;
      end
      granted = bus.mem_gnt;
      @(posedge clk); #1;
      cyc++;
    end
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 32'h0;
    obs_lat   = bus.resp_valid ? cyc : -1;
    if (bus.req_ready) obs_ready_early = 1'b1;
    obs_rdata = bus.resp_rdata;
    obs_err   = bus.resp_err;
    @(posedge clk); #1;
    obs_pulse_ok    = !bus.resp_valid;
    obs_ready_after = bus.req_ready;
    obs_hold        = (bus.resp_rdata == obs_rdata) && (bus.resp_err == obs_err);
  endtask

  task automatic checkCommon(input string tag, input int lat);
    checkOutput({tag, "_latency"}, 32'(obs_lat), 32'(lat));
    checkOutput({tag, "_ready_low"}, 32'(obs_ready_early), 32'd0);
    checkOutput({tag, "_pulse"}, 32'(obs_pulse_ok), 32'd1);
    checkOutput({tag, "_ready_after"}, 32'(obs_ready_after), 32'd1);
    checkOutput({tag, "_hold"}, 32'(obs_hold), 32'd1);
  endtask

  initial begin
    int stray;
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'b000;
    bus.req_addr  = 32'h0; bus.req_wdata = 32'h0;
    bus.mem_gnt   = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'h0;

    @(posedge clk); #1;
    checkOutput("rst_req_ready", 32'(bus.req_ready), 32'd0);
    checkOutput("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    checkOutput("rst_mem_req", 32'(bus.mem_req), 32'd0);
    checkOutput("rst_resp_rdata", bus.resp_rdata, 32'h0);
    checkOutput("rst_mem_be", 32'(bus.mem_be), 32'h0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("hold_edge2_ready", 32'(bus.req_ready), 32'd0);
    @(posedge clk); #1;
    checkOutput("hold_edge3_ready", 32'(bus.req_ready), 32'd1);

    $display("[TB] LB at 0x1003, zero-wait");
    applyStimulus(1'b0, 3'b000, 32'h0000_1003, 32'h0, 32'h80FF_1234, 0);
    checkOutput("lb_be", 32'(obs_be), 32'h8);
    checkOutput("lb_addr", obs_addr, 32'h0000_1000);
    checkOutput("lb_we", 32'(obs_we), 32'd0);
    checkOutput("lb_rdata", obs_rdata, 32'hFFFF_FF80);
    checkOutput("lb_err", 32'(obs_err), 32'd0);
    checkOutput("lb_req_ok", 32'(obs_req_ok), 32'd1);
    checkCommon("lb", 3);

    applyStimulus(1'b0, 3'b100, 32'h0000_1001, 32'h0, 32'h80FF_1234, 0);
    checkOutput("lbu_be", 32'(obs_be), 32'h2);
    checkOutput("lbu_rdata", obs_rdata, 32'h0000_0012);

    applyStimulus(1'b0, 3'b101, 32'h0000_2002, 32'h0, 32'hBEEF_0000, 0);
    checkOutput("lhu_be", 32'(obs_be), 32'hC);
    checkOutput("lhu_addr", obs_addr, 32'h0000_2000);
    checkOutput("lhu_rdata", obs_rdata, 32'h0000_BEEF);
    applyStimulus(1'b0, 3'b001, 32'h0000_2002, 32'h0, 32'hBEEF_0000, 1);
    checkOutput("lh_rdata", obs_rdata, 32'hFFFF_BEEF);
    checkOutput("lh_latency", 32'(obs_lat), 32'd4);

    // Stray grant/rvalid while idle must not produce a response or alter held data.
    bus.mem_gnt = 1'b1; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'h0;
    checkOutput("idle_stray_resp", 32'(bus.resp_valid), 32'd0);
    checkOutput("idle_stray_rdata", bus.resp_rdata, 32'hFFFF_BEEF);

    $display("[TB] SB 0xA5 to 0x3001, grant delayed 4");
    applyStimulus(1'b1, 3'b000, 32'h0000_3001, 32'h1234_56A5, 32'hDEAD_DEAD, 4);
    checkOutput("sb_be", 32'(obs_be), 32'h2);
    checkOutput("sb_addr", obs_addr, 32'h0000_3000);
    checkOutput("sb_wdata", obs_wdata, 32'hA5A5_A5A5);
    checkOutput("sb_we", 32'(obs_we), 32'd1);
    checkOutput("sb_req_ok", 32'(obs_req_ok), 32'd1);
    checkOutput("sb_rdata", obs_rdata, 32'h0);
    checkOutput("sb_err", 32'(obs_err), 32'd0);
    checkCommon("sb", 7);

    applyStimulus(1'b1, 3'b001, 32'h0000_6002, 32'h1234_BEEF, 32'h0, 0);
    checkOutput("sh_be", 32'(obs_be), 32'hC);
    checkOutput("sh_wdata", obs_wdata, 32'hBEEF_BEEF);
    applyStimulus(1'b1, 3'b010, 32'h0000_7000, 32'hDEAD_BEEF, 32'h0, 0);
    checkOutput("sw_be", 32'(obs_be), 32'hF);
    checkOutput("sw_wdata", obs_wdata, 32'hDEAD_BEEF);

    applyStimulus(1'b1, 3'b100, 32'h0000_7000, 32'hDEAD_BEEF, 32'h0, 0);
    checkOutput("st_bad_err", 32'(obs_err), 32'd1);
    checkOutput("st_bad_noreq", 32'(obs_saw_req), 32'd0);

    applyStimulus(1'b0, 3'b011, 32'h0000_5000, 32'h0, 32'h1111_1111, 0);
    checkOutput("ld011_err", 32'(obs_err), 32'd1);
    checkOutput("ld011_noreq", 32'(obs_saw_req), 32'd0);
    checkOutput("ld011_rdata", obs_rdata, 32'h0);
    checkCommon("ld011", 1);

    $display("[TB] LW at 0x4002");
    applyStimulus(1'b0, 3'b010, 32'h0000_4002, 32'h0, 32'h1122_3344, 0);
`ifdef LSU_MISALIGN_TRAP_EN
    checkOutput("lw_mis_err", 32'(obs_err), 32'd1);
    checkOutput("lw_mis_noreq", 32'(obs_saw_req), 32'd0);
    checkOutput("lw_mis_rdata", obs_rdata, 32'h0);
    checkCommon("lw_mis", 1);
`else
    checkOutput("lw_mis_addr", obs_addr, 32'h0000_4000);
    checkOutput("lw_mis_be", 32'(obs_be), 32'hF);
    checkOutput("lw_mis_err", 32'(obs_err), 32'd0);
    checkOutput("lw_mis_rdata", obs_rdata, 32'h1122_3344);
    checkCommon("lw_mis", 3);
`endif

    $display("[TB] reset during WAIT");
    waitReady();
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_funct3 = 3'b010; bus.req_addr = 32'h0000_8000;
    @(posedge clk); #1;
    bus.req_valid = 1'b0; bus.req_funct3 = 3'b000; bus.req_addr = 32'h0;
    checkOutput("mid_mem_req", 32'(bus.mem_req), 32'd1);
    bus.mem_gnt = 1'b1;
    @(posedge clk); #1;
    bus.mem_gnt = 1'b0;
    checkOutput("mid_wait_req_drop", 32'(bus.mem_req), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("mid_rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    checkOutput("mid_rst_ready", 32'(bus.req_ready), 32'd0);
    checkOutput("mid_rst_mem_addr", bus.mem_addr, 32'h0);
    checkOutput("mid_rst_mem_be", 32'(bus.mem_be), 32'h0);
    checkOutput("mid_rst_rdata", bus.resp_rdata, 32'h0);
    checkOutput("mid_rst_err", 32'(bus.resp_err), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hFFFF_FFFF;
    stray = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (bus.resp_valid || bus.mem_req) stray++;
    end
    bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'h0;
    checkOutput("late_rvalid_ignored", 32'(stray), 32'd0);

    applyStimulus(1'b0, 3'b000, 32'h0000_9002, 32'h0, 32'h0055_0000, 0);
    checkOutput("recover_rdata", obs_rdata, 32'h0000_0055);
    checkOutput("recover_be", 32'(obs_be), 32'h4);
    checkCommon("recover", 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

endmodule
